regfile_sb: RTL and testbench

Parametrised multi-read-port register file with same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register pending-write scoreboard. It replaces the fixed two-read-port register file in the pipelined LEGv8 datapath. Decode reserves destination registers, and writeback clears them. Each read port reports whether its operand is valid this cycle, so hazard logic can stall without keeping its own tracking.

---
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-read-port register file with write bypass, optional zero register
// and a per-register pending-write scoreboard.  Rev 1.0
`default_nettype none

module regfile_sb #(
  parameter int REG_WIDTH   = 64,
  parameter int NUM_REGS    = 32,
  parameter int NUM_READ    = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RegWrite,
  input  logic [AW-1:0]                 WriteRegister,
  input  logic [REG_WIDTH-1:0]          WriteData,
  input  logic                          Reserve,
  input  logic [AW-1:0]                 ReserveRegister,
  input  logic [NUM_READ*AW-1:0]        ReadRegister,
  output logic [NUM_READ*REG_WIDTH-1:0] ReadData,
  output logic [NUM_READ-1:0]           ReadReady,
  output logic [NUM_REGS-1:0]           Busy
);

  // True for indices that name a real, writable register.
  function automatic logic idx_valid(input logic [AW-1:0] idx);
    logic in_range;
    logic is_zero;
    in_range = int'(idx) < NUM_REGS;
    is_zero  = (ZERO_REG_EN != 0) && (int'(idx) == NUM_REGS - 1);
    return in_range && !is_zero;
  endfunction

  logic [NUM_REGS-1:0]  wr_sel;
  logic [NUM_REGS-1:0]  rsv_sel;
  logic [NUM_REGS-1:0]  pending_d;
  logic [NUM_REGS-1:0]  pending_q;
  logic [REG_WIDTH-1:0] reg_val [NUM_REGS];

  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i]  = RegWrite && idx_valid(WriteRegister) && (int'(WriteRegister) == i);
      rsv_sel[i] = Reserve && idx_valid(ReserveRegister) && (int'(ReserveRegister) == i);
    end
  end

  // A reserve in the same cycle as a write to that register names a newer producer,
  // so the set takes priority over the clear.
  always_comb begin
    pending_d = (pending_q & ~wr_sel) | rsv_sel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign Busy = pending_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if ((ZERO_REG_EN != 0) && (i == NUM_REGS - 1)) begin : g_zero
      assign reg_val[i] = '0;
    end else begin : g_store
      logic [REG_WIDTH-1:0] data_d;
      logic [REG_WIDTH-1:0] data_q;

      always_comb begin
        data_d = data_q;
        if (wr_sel[i]) begin
          data_d = WriteData;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign reg_val[i] = data_q;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0]        rd_idx;
    logic [REG_WIDTH-1:0] rd_data;
    logic                 rd_ready;

    assign rd_idx = ReadRegister[k*AW +: AW];

    always_comb begin
      rd_data  = '0;
      rd_ready = 1'b1;
      if (!idx_valid(rd_idx)) begin
        rd_data  = '0;
        rd_ready = 1'b1;
      end else if ((BYPASS_EN != 0) && RegWrite && (WriteRegister == rd_idx)) begin
        rd_data  = WriteData;
        rd_ready = 1'b1;
      end else begin
        rd_data  = reg_val[rd_idx];
        rd_ready = !pending_q[rd_idx];
      end
    end

    assign ReadData[k*REG_WIDTH +: REG_WIDTH] = rd_data;
    assign ReadReady[k]                       = rd_ready;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed table-driven bench for regfile_sb (default, no-bypass and
// 4-port/24-register builds).
`default_nettype none

module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the default build and the no-bypass build.
  logic         we = 1'b0;
  logic [4:0]   wa = '0;
  logic [63:0]  wd = '0;
  logic         rsv = 1'b0;
  logic [4:0]   ra = '0;
  logic [9:0]   rr = '0;
  logic [127:0] rd_a, rd_n;
  logic [1:0]   rdy_a, rdy_n;
  logic [31:0]  busy_a, busy_n;

  // 4-port / 24-register build.
  logic         s_we = 1'b0;
  logic [4:0]   s_wa = '0;
  logic [63:0]  s_wd = '0;
  logic         s_rsv = 1'b0;
  logic [4:0]   s_ra = '0;
  logic [19:0]  s_rr = '0;
  logic [255:0] s_rd;
  logic [3:0]   s_rdy;
  logic [23:0]  s_busy;

  regfile_sb dut_a (
    .clk(clk), .reset(rst_n), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .Reserve(rsv), .ReserveRegister(ra), .ReadRegister(rr), .ReadData(rd_a),
    .ReadReady(rdy_a), .Busy(busy_a)
  );

  regfile_sb #(.BYPASS_EN(0)) dut_n (
    .clk(clk), .reset(rst_n), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .Reserve(rsv), .ReserveRegister(ra), .ReadRegister(rr), .ReadData(rd_n),
    .ReadReady(rdy_n), .Busy(busy_n)
  );

  regfile_sb #(.NUM_READ(4), .NUM_REGS(24)) dut_s (
    .clk(clk), .reset(rst_n), .RegWrite(s_we), .WriteRegister(s_wa), .WriteData(s_wd),
    .Reserve(s_rsv), .ReserveRegister(s_ra), .ReadRegister(s_rr), .ReadData(s_rd),
    .ReadReady(s_rdy), .Busy(s_busy)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        chk;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  rdy;
    logic [31:0] busy;
    logic [63:0] nd0;
    logic [63:0] nd1;
    logic [1:0]  nrdy;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic w, input logic [4:0] a, input logic [63:0] d,
    input logic s, input logic [4:0] sa, input logic [4:0] p0, input logic [4:0] p1,
    input logic c, input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] er,
    input logic [31:0] eb, input logic [63:0] n0, input logic [63:0] n1, input logic [1:0] nr);
    vec_t v;
    v.rst_n = r; v.we = w; v.wa = a; v.wd = d; v.rsv = s; v.ra = sa; v.r0 = p0; v.r1 = p1;
    v.chk = c; v.d0 = e0; v.d1 = e1; v.rdy = er; v.busy = eb;
    v.nd0 = n0; v.nd1 = n1; v.nrdy = nr;
    return v;
  endfunction

  localparam int NV = 20;
  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rst we wa  wd        rsv ra  r0  r1  chk d0      d1      rdy    busy        nd0     nd1     nrdy
    vecs[0]  = mk(0, 0, 0,  64'h0,    0, 0,  0,  0,  0, 64'h0,  64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[1]  = mk(1, 0, 0,  64'h0,    0, 0,  0,  5,  1, 64'h0,  64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[2]  = mk(1, 1, 3,  DB,       0, 0,  30, 31, 1, 64'h0,  64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[3]  = mk(1, 1, 31, 64'hFFFF, 0, 0,  3,  0,  1, DB,     64'h0,  2'b11, 32'h0,      DB,     64'h0,  2'b11);
    vecs[4]  = mk(1, 0, 0,  64'h0,    0, 0,  31, 31, 1, 64'h0,  64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[5]  = mk(1, 1, 7,  64'h1234, 0, 0,  7,  7,  1, 64'h1234, 64'h1234, 2'b11, 32'h0,  64'h0,  64'h0,  2'b11);
    vecs[6]  = mk(1, 0, 0,  64'h0,    0, 0,  7,  3,  1, 64'h1234, DB,   2'b11, 32'h0,      64'h1234, DB,   2'b11);
    vecs[7]  = mk(1, 0, 0,  64'h0,    1, 9,  9,  9,  1, 64'h0,  64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[8]  = mk(1, 0, 0,  64'h0,    0, 0,  9,  0,  1, 64'h0,  64'h0,  2'b10, 32'h200,    64'h0,  64'h0,  2'b10);
    vecs[9]  = mk(1, 1, 9,  64'h55,   0, 0,  9,  9,  1, 64'h55, 64'h55, 2'b11, 32'h200,    64'h0,  64'h0,  2'b00);
    vecs[10] = mk(1, 0, 0,  64'h0,    1, 31, 9,  31, 1, 64'h55, 64'h0,  2'b11, 32'h0,      64'h55, 64'h0,  2'b11);
    vecs[11] = mk(1, 1, 4,  64'h4444, 1, 4,  4,  6,  1, 64'h4444, 64'h0, 2'b11, 32'h0,     64'h0,  64'h0,  2'b11);
    vecs[12] = mk(1, 1, 6,  64'h66,   1, 4,  4,  6,  1, 64'h4444, 64'h66, 2'b10, 32'h10,   64'h4444, 64'h0, 2'b10);
    vecs[13] = mk(1, 0, 0,  64'h0,    0, 0,  4,  6,  1, 64'h4444, 64'h66, 2'b10, 32'h10,   64'h4444, 64'h66, 2'b10);
    vecs[14] = mk(1, 1, 2,  64'hAA,   1, 2,  2,  10, 1, 64'hAA, 64'h0,  2'b11, 32'h10,     64'h0,  64'h0,  2'b11);
    vecs[15] = mk(1, 0, 0,  64'h0,    1, 10, 2,  10, 1, 64'hAA, 64'h0,  2'b10, 32'h14,     64'hAA, 64'h0,  2'b10);
    vecs[16] = mk(0, 1, 10, 64'hBB,   0, 0,  2,  10, 1, 64'hAA, 64'hBB, 2'b10, 32'h414,    64'hAA, 64'h0,  2'b00);
    vecs[17] = mk(1, 0, 0,  64'h0,    0, 0,  2,  10, 1, 64'h0,  64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[18] = mk(1, 1, 10, 64'hCC,   0, 0,  10, 4,  1, 64'hCC, 64'h0,  2'b11, 32'h0,      64'h0,  64'h0,  2'b11);
    vecs[19] = mk(1, 0, 0,  64'h0,    0, 0,  10, 10, 1, 64'hCC, 64'hCC, 2'b11, 32'h0,      64'hCC, 64'hCC, 2'b11);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst_n; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      rsv = vecs[i].rsv; ra = vecs[i].ra; rr = {vecs[i].r1, vecs[i].r0};
      #3;
      if (vecs[i].chk) begin
        check($sformatf("row%0d d0", i),   rd_a[63:0],    vecs[i].d0);
        check($sformatf("row%0d d1", i),   rd_a[127:64],  vecs[i].d1);
        check($sformatf("row%0d rdy", i),  64'(rdy_a),    64'(vecs[i].rdy));
        check($sformatf("row%0d busy", i), 64'(busy_a),   64'(vecs[i].busy));
        check($sformatf("row%0d nb_d0", i),  rd_n[63:0],   vecs[i].nd0);
        check($sformatf("row%0d nb_d1", i),  rd_n[127:64], vecs[i].nd1);
        check($sformatf("row%0d nb_rdy", i), 64'(rdy_n),   64'(vecs[i].nrdy));
      end
    end
    @(posedge clk);
    #1;
    we = 1'b0; rsv = 1'b0; rst_n = 1'b1;

    // 24-register, 4-port build: index 30 is out of range, 23 is the zero register.
    s_we = 1'b1; s_wa = 5'd30; s_wd = '1;
    s_rr = {5'd30, 5'd5, 5'd23, 5'd30};
    #3;
    check("s_a rd", s_rd[63:0] | s_rd[127:64] | s_rd[191:128] | s_rd[255:192], 64'h0);
    check("s_a rdy", 64'(s_rdy), 64'hF);
    check("s_a busy", 64'(s_busy), 64'h0);

    @(posedge clk); #1;
    s_we = 1'b1; s_wa = 5'd5; s_wd = 64'h77; s_rsv = 1'b1; s_ra = 5'd30;
    s_rr = {5'd22, 5'd23, 5'd30, 5'd5};
    #3;
    check("s_b p0", s_rd[63:0], 64'h77);
    check("s_b p3", s_rd[255:192], 64'h0);
    check("s_b rdy", 64'(s_rdy), 64'hF);

    @(posedge clk); #1;
    s_we = 1'b0; s_rsv = 1'b1; s_ra = 5'd23;
    s_rr = {5'd30, 5'd23, 5'd22, 5'd5};
    #3;
    check("s_c p0", s_rd[63:0], 64'h77);
    check("s_c busy", 64'(s_busy), 64'h0);

    @(posedge clk); #1;
    s_rsv = 1'b1; s_ra = 5'd22;
    #3;
    check("s_d busy", 64'(s_busy), 64'h0);
    check("s_d rdy", 64'(s_rdy), 64'hF);

    @(posedge clk); #1;
    s_rsv = 1'b0;
    #3;
    check("s_e rdy", 64'(s_rdy), 64'hD);
    check("s_e busy", 64'(s_busy), 64'h40_0000);
    check("s_e p0", s_rd[63:0], 64'h77);
    check("s_e p1", s_rd[127:64], 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
